// File: rtl/tour_cmd_pkg.sv
// tour_cmd_pkg: shared state encoding, cmd_proc opcodes, headings and response codes
package tour_cmd_pkg;
  typedef enum logic [2:0] {IDLE, LEG1, HOLD1, LEG2, HOLD2} state_t;
  localparam logic [3:0] OPC_HORI  = 4'b0010;
  localparam logic [3:0] OPC_VERT  = 4'b0011;
  localparam logic [7:0] HDG_UP    = 8'h00;
  localparam logic [7:0] HDG_DOWN  = 8'h7F;
  localparam logic [7:0] HDG_RIGHT = 8'hBF;
  localparam logic [7:0] HDG_LEFT  = 8'h3F;
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;
endpackage

// File: rtl/tour_move_decode.sv
// tour_move_decode: one-hot knight move -> horizontal and vertical cmd_proc commands
// Ports: move (one-hot move) -> valid (exactly one bit set), hori_cmd, vert_cmd
module tour_move_decode
  import tour_cmd_pkg::*;
(
  input  logic [7:0]  move,
  output logic        valid,
  output logic [15:0] hori_cmd,
  output logic [15:0] vert_cmd
);
  logic right, up, two_x, two_y;
  // bits 1,5,6,7 move right; bits 0,1,2,7 move up; the other axis takes the 2-square leg
  assign right    = move[1] | move[5] | move[6] | move[7];
  assign up       = move[0] | move[1] | move[2] | move[7];
  assign two_x    = move[2] | move[3] | move[6] | move[7];
  assign two_y    = move[0] | move[1] | move[4] | move[5];
  assign valid    = $onehot(move);
  assign hori_cmd = {OPC_HORI, right ? HDG_RIGHT : HDG_LEFT, two_x ? 4'd2 : 4'd1};
  assign vert_cmd = {OPC_VERT, up ? HDG_UP : HDG_DOWN, two_y ? 4'd2 : 4'd1};
endmodule

// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: muxes UART commands to cmd_proc in idle and replays a knight's tour as leg commands
// Ports: start_tour/move/mv_indx to the solver, cmd_UART/cmd_rdy_UART from UART,
//        cmd/cmd_rdy/clr_cmd_rdy/send_resp with cmd_proc, resp/tour_busy/err_move status.
// Optional: TOUR_ABORT_EN enables a UART abort opcode while touring.
module tour_cmd_seq
  import tour_cmd_pkg::*;
#(
  parameter int         BOARD_DIM  = 5,
  parameter int         IDX_W      = $clog2(BOARD_DIM*BOARD_DIM),
  parameter bit         VERT_FIRST = 1'b0,
  parameter logic [3:0] ABORT_OPC  = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             err_move
);
  localparam int NUM_MOVES = BOARD_DIM*BOARD_DIM-1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MOVES-1);
`ifdef TOUR_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif
  state_t state_q, state_d, adv_state;
  logic [IDX_W-1:0] mv_indx_q, mv_indx_d, adv_indx;
  logic err_move_q, err_move_d;
  logic valid, last, abort;
  logic [15:0] hori_cmd, vert_cmd, leg1_cmd, leg2_cmd;
  tour_move_decode u_dec (.move(move), .valid(valid), .hori_cmd(hori_cmd), .vert_cmd(vert_cmd));
  assign leg1_cmd  = VERT_FIRST ? vert_cmd : hori_cmd;
  assign leg2_cmd  = VERT_FIRST ? hori_cmd : vert_cmd;
  assign last      = mv_indx_q == LAST;
  assign abort     = ABORT_EN && cmd_rdy_UART && cmd_UART[15:12] == ABORT_OPC;
  // end-of-move step shared by HOLD2 completion and skipping an illegal move
  assign adv_state = last ? IDLE : LEG1;
  assign adv_indx  = last ? mv_indx_q : mv_indx_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      mv_indx_q  <= '0;
      err_move_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mv_indx_q  <= mv_indx_d;
      err_move_q <= err_move_d;
    end
  always_comb begin
    state_d    = state_q;
    mv_indx_d  = mv_indx_q;
    err_move_d = err_move_q;
    case (state_q)
      IDLE:  if (start_tour) begin
               state_d    = LEG1;
               mv_indx_d  = '0;
               err_move_d = 1'b0;
             end
      LEG1:  if (!valid) begin
               state_d    = adv_state;
               mv_indx_d  = adv_indx;
               err_move_d = 1'b1;
             end else if (clr_cmd_rdy) state_d = HOLD1;
      HOLD1: if (send_resp) state_d = LEG2;
      LEG2:  if (clr_cmd_rdy) state_d = HOLD2;
      HOLD2: if (send_resp) begin
               state_d   = adv_state;
               mv_indx_d = adv_indx;
             end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      mv_indx_d  = mv_indx_q;
      err_move_d = err_move_q;
    end
  end
  always_comb begin
    tour_busy = state_q != IDLE;
    cmd       = state_q == IDLE ? cmd_UART : state_q == LEG1 ? leg1_cmd : leg2_cmd;
    cmd_rdy   = state_q == IDLE ? cmd_rdy_UART : state_q == LEG1 ? valid : state_q == LEG2;
    resp      = (state_q == IDLE || (state_q == HOLD2 && last)) ? RESP_DONE : RESP_BUSY;
  end
  assign mv_indx  = mv_indx_q;
  assign err_move = err_move_q;
endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb_tour_cmd_seq: randomized bench for tour_cmd_seq against a move-table reference model
module tb_tour_cmd_seq;
  logic clk = 1'b0, rst_n = 1'b0, start_tour = 1'b0, cmd_rdy_UART = 1'b0;
  logic clr_cmd_rdy = 1'b0, send_resp = 1'b0;
  logic [15:0] cmd_UART = '0;
  logic [7:0] move;
  logic [4:0] mv_indx, mv_indx_v;
  logic [15:0] cmd, cmd_v;
  logic cmd_rdy, cmd_rdy_v, tour_busy, tour_busy_v, err_move, err_move_v;
  logic [7:0] resp, resp_v;
  logic [7:0] mem [25];
  int n_cmp = 0, n_bad = 0;
  int dxt [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
  int dyt [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  always #5 clk = ~clk;
  assign move = mem[mv_indx];

  tour_cmd_seq #(.BOARD_DIM(5), .VERT_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp(resp),
    .tour_busy(tour_busy), .err_move(err_move));
  tour_cmd_seq #(.BOARD_DIM(5), .VERT_FIRST(1'b1)) dut_v (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx_v),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .cmd(cmd_v), .cmd_rdy(cmd_rdy_v), .resp(resp_v),
    .tour_busy(tour_busy_v), .err_move(err_move_v));

  function automatic int bit_of(logic [7:0] m);
    int k = 0;
    for (int b = 0; b < 8; b++) if (m[b]) k = b;
    return k;
  endfunction
  function automatic logic [15:0] exp_h(logic [7:0] m);
    int dx = dxt[bit_of(m)];
    return {4'b0010, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
  endfunction
  function automatic logic [15:0] exp_v(logic [7:0] m);
    int dy = dyt[bit_of(m)];
    return {4'b0011, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic quiet;
    start_tour = 0; clr_cmd_rdy = 0; send_resp = 0; cmd_rdy_UART = 0; cmd_UART = '0;
  endtask
  task automatic noise;
    cmd_UART = {4'($urandom_range(0, 14)), 12'($urandom)};
    cmd_rdy_UART = 1'($urandom);
    start_tour = 1'($urandom);
  endtask
  task automatic hard_reset;
    rst_n = 0;
    #1;
    if (tour_busy !== 1'b0 || cmd_rdy !== cmd_rdy_UART) begin
      n_bad++; $display("FAIL async_reset busy=%b rdy=%b exp busy=0 rdy=%b", tour_busy, cmd_rdy, cmd_rdy_UART);
    end
    n_cmp++;
    quiet();
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset;
    cmd_UART = 16'h1234; cmd_rdy_UART = 1;
    #2;
    if ({tour_busy, err_move, mv_indx} !== 7'd0) begin
      n_bad++; $display("FAIL reset_regs busy=%b err=%b idx=%0d exp 0/0/0", tour_busy, err_move, mv_indx);
    end
    n_cmp++;
    if (cmd !== 16'h1234 || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin
      n_bad++; $display("FAIL reset_outs cmd=%h rdy=%b resp=%h exp 1234/1/a5", cmd, cmd_rdy, resp);
    end
    n_cmp++;
    quiet();
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_uart_passthrough;
    logic [15:0] c;
    logic r;
    for (int i = 0; i < 7; i++) begin
      c = (i == 0) ? 16'h2BF1 : 16'($urandom);
      r = (i == 0) ? 1'b1 : 1'($urandom);
      cmd_UART = c; cmd_rdy_UART = r; clr_cmd_rdy = 1'($urandom); send_resp = 1'($urandom);
      #1;
      if (cmd !== c || cmd_rdy !== r || resp !== 8'hA5 || tour_busy !== 1'b0) begin
        n_bad++; $display("FAIL passthrough cmd=%h rdy=%b resp=%h busy=%b exp %h/%b/a5/0", cmd, cmd_rdy, resp, tour_busy, c, r);
      end
      n_cmp++;
      tick();
    end
    quiet();
  endtask

  task automatic test_single_move;
    mem[0] = 8'h02;
    start_tour = 1; tick(); start_tour = 0;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h2BF1 || cmd_v !== 16'h3002) begin
      n_bad++; $display("FAIL single_leg1 rdy=%b cmd=%h cmd_v=%h exp 1/2bf1/3002", cmd_rdy, cmd, cmd_v);
    end
    n_cmp++;
    clr_cmd_rdy = 1; tick(); clr_cmd_rdy = 0;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h3002) begin
      n_bad++; $display("FAIL single_hold1 rdy=%b cmd=%h exp 0/3002", cmd_rdy, cmd);
    end
    n_cmp++;
    send_resp = 1; tick(); send_resp = 0;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h3002 || cmd_v !== 16'h2BF1) begin
      n_bad++; $display("FAIL single_leg2 rdy=%b cmd=%h cmd_v=%h exp 1/3002/2bf1", cmd_rdy, cmd, cmd_v);
    end
    n_cmp++;
    hard_reset();
  endtask

  task automatic test_ordering;
    mem[0] = 8'h40;
    start_tour = 1; tick(); start_tour = 0;
    if (cmd_rdy_v !== 1'b1 || cmd_v !== 16'h37F1 || cmd !== 16'h2BF2) begin
      n_bad++; $display("FAIL order_leg1 rdy_v=%b cmd_v=%h cmd=%h exp 1/37f1/2bf2", cmd_rdy_v, cmd_v, cmd);
    end
    n_cmp++;
    clr_cmd_rdy = 1; tick(); clr_cmd_rdy = 0;
    send_resp = 1; tick(); send_resp = 0;
    if (cmd_rdy_v !== 1'b1 || cmd_v !== 16'h2BF2) begin
      n_bad++; $display("FAIL order_leg2 rdy_v=%b cmd_v=%h exp 1/2bf2", cmd_rdy_v, cmd_v);
    end
    n_cmp++;
    hard_reset();
  endtask

  task automatic test_full_tour(input bit inject);
    logic [7:0] m, r;
    logic [15:0] h, v;
    bit exp_err = 0;
    int nvalid = 0, nseen = 0;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do r = 8'($urandom); while ($countones(r) == 1);
        mem[i] = r;
      end else mem[i] = 8'(1 << $urandom_range(0, 7));
    end
    if (inject) mem[4] = 8'h03;
    start_tour = 1; tick(); start_tour = 0;
    if (mv_indx !== 5'd0 || err_move !== 1'b0) begin
      n_bad++; $display("FAIL tour_start idx=%0d err=%b exp 0/0", mv_indx, err_move);
    end
    n_cmp++;
    for (int i = 0; i < 24; i++) begin
      m = mem[i]; h = exp_h(m); v = exp_v(m);
      noise();
      #1;
      if (mv_indx !== 5'(i) || tour_busy !== 1'b1 || err_move !== exp_err) begin
        n_bad++; $display("FAIL tour_idx got idx=%0d busy=%b err=%b exp %0d/1/%b", mv_indx, tour_busy, err_move, i, exp_err);
      end
      n_cmp++;
      if ($countones(m) != 1) begin
        if (cmd_rdy !== 1'b0 || cmd_rdy_v !== 1'b0 || resp !== 8'h5A) begin
          n_bad++; $display("FAIL bad_move i=%0d rdy=%b rdy_v=%b resp=%h exp 0/0/5a", i, cmd_rdy, cmd_rdy_v, resp);
        end
        n_cmp++;
        tick();
        exp_err = 1;
        continue;
      end
      nvalid++;
      for (int w = $urandom_range(0, 2); w >= 0; w--) begin
        if (cmd_rdy !== 1'b1 || cmd !== h || cmd_v !== v || resp !== 8'h5A) begin
          n_bad++; $display("FAIL leg1 i=%0d rdy=%b cmd=%h cmd_v=%h resp=%h exp 1/%h/%h/5a", i, cmd_rdy, cmd, cmd_v, resp, h, v);
        end
        n_cmp++;
        if (w > 0) begin send_resp = 1'($urandom); tick(); noise(); #1; end
      end
      if (cmd_rdy) nseen++;
      clr_cmd_rdy = 1; send_resp = 1'($urandom); tick(); clr_cmd_rdy = 0; send_resp = 0;
      for (int w = $urandom_range(0, 2); w >= 0; w--) begin
        noise();
        #1;
        if (cmd_rdy !== 1'b0 || cmd !== v || resp !== 8'h5A) begin
          n_bad++; $display("FAIL hold1 i=%0d rdy=%b cmd=%h resp=%h exp 0/%h/5a", i, cmd_rdy, cmd, resp, v);
        end
        n_cmp++;
        if (w > 0) begin clr_cmd_rdy = 1'($urandom); tick(); clr_cmd_rdy = 0; end
      end
      send_resp = 1; clr_cmd_rdy = 1'($urandom); tick(); send_resp = 0; clr_cmd_rdy = 0;
      noise();
      #1;
      if (cmd_rdy !== 1'b1 || cmd !== v || cmd_v !== h) begin
        n_bad++; $display("FAIL leg2 i=%0d rdy=%b cmd=%h cmd_v=%h exp 1/%h/%h", i, cmd_rdy, cmd, cmd_v, v, h);
      end
      n_cmp++;
      if (cmd_rdy) nseen++;
      clr_cmd_rdy = 1; send_resp = 1'($urandom); tick(); clr_cmd_rdy = 0; send_resp = 0;
      for (int w = $urandom_range(0, 1); w >= 0; w--) begin
        noise();
        #1;
        if (cmd_rdy !== 1'b0 || resp !== ((i == 23) ? 8'hA5 : 8'h5A)) begin
          n_bad++; $display("FAIL hold2 i=%0d rdy=%b resp=%h exp 0/%h", i, cmd_rdy, resp, (i == 23) ? 8'hA5 : 8'h5A);
        end
        n_cmp++;
        if (w > 0) begin clr_cmd_rdy = 1'($urandom); tick(); clr_cmd_rdy = 0; end
      end
      send_resp = 1; tick(); send_resp = 0;
    end
    quiet();
    #1;
    if (tour_busy !== 1'b0 || tour_busy_v !== 1'b0 || resp !== 8'hA5 || mv_indx !== 5'd23 || err_move !== exp_err) begin
      n_bad++; $display("FAIL tour_end busy=%b busy_v=%b resp=%h idx=%0d err=%b exp 0/0/a5/23/%b", tour_busy, tour_busy_v, resp, mv_indx, err_move, exp_err);
    end
    n_cmp++;
    if (nseen != 2 * nvalid) begin
      n_bad++; $display("FAIL cmd_count got=%0d exp=%0d", nseen, 2 * nvalid);
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_abort;
    mem[0] = 8'h02;
    start_tour = 1; tick(); start_tour = 0;
    clr_cmd_rdy = 1; tick(); clr_cmd_rdy = 0;
    cmd_UART = 16'hF000; cmd_rdy_UART = 1;
    #1;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h3002) begin
      n_bad++; $display("FAIL abort_no_fwd rdy=%b cmd=%h exp 0/3002", cmd_rdy, cmd);
    end
    n_cmp++;
    tick();
`ifdef TOUR_ABORT_EN
    if (tour_busy !== 1'b0 || mv_indx !== 5'd0) begin
      n_bad++; $display("FAIL abort_idle busy=%b idx=%0d exp 0/0", tour_busy, mv_indx);
    end
    n_cmp++;
    quiet();
    tick();
`else
    if (tour_busy !== 1'b1 || cmd_rdy !== 1'b0) begin
      n_bad++; $display("FAIL abort_ignored busy=%b rdy=%b exp 1/0", tour_busy, cmd_rdy);
    end
    n_cmp++;
    hard_reset();
`endif
  endtask

  initial begin
    for (int i = 0; i < 25; i++) mem[i] = 8'h01;
    test_reset();
    test_uart_passthrough();
    test_single_move();
    test_ordering();
    test_full_tour(1'b1);
    test_full_tour(1'b0);
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end
endmodule
